// File: rtl/pot_paddle_filter_if.sv
// Paddle filter interface.
// Purpose : bundles the potentiometer sample / frame strobe inputs and the
//           filtered reading / paddle position outputs of pot_paddle_filter.
// Signals : value      raw 8-bit potentiometer reading
//           frame_tick single-cycle pulse per video frame
//           filt_value averaged, deadbanded reading
//           paddle_y   paddle top coordinate
//           moved      one-cycle pulse when paddle_y changed
// Modports: master drives value/frame_tick, slave (the filter) drives results.
interface pot_paddle_filter_if;
  logic [7:0] value;
  logic       frame_tick;
  logic [7:0] filt_value;
  logic [9:0] paddle_y;
  logic       moved;

  modport master (output value, frame_tick, input filt_value, paddle_y, moved);
  modport slave  (input value, frame_tick, output filt_value, paddle_y, moved);
endinterface

// File: rtl/pot_paddle_filter.sv
// Potentiometer paddle filter.
// Purpose : decimates the raw pot reading, runs a 2^AVG_LOG2-deep moving
//           average, applies a deadband, scales to 0..Y_RANGE-1 and steps
//           the paddle toward that target by at most MAX_STEP per frame.
// Ports   : sys_clk  system clock
//           reset    asynchronous, active-low reset
//           pif      pot_paddle_filter_if.slave (value, frame_tick in;
//                    filt_value, paddle_y, moved out)
module pot_paddle_filter #(
  parameter int SAMPLE_DIV = 100000,
  parameter int AVG_LOG2   = 3,
  parameter int DEADBAND   = 2,
  parameter int Y_RANGE    = 400,
  parameter int MAX_STEP   = 4
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  pot_paddle_filter_if.slave   pif
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int CW    = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SW    = 8 + AVG_LOG2;
  // Steps larger than the coordinate range behave like an unlimited step.
  localparam logic [9:0] STEP = (MAX_STEP > 1023) ? 10'd1023 : 10'(MAX_STEP);

  logic [CW-1:0]               cnt_q;
  logic [DEPTH-1:0][7:0]       smp_q;
  logic [AVG_LOG2-1:0]         wp_q;
  logic [SW-1:0]               sum_q, sum_d;
  logic                        tick_d1_q;
  logic [7:0]                  filt_q;
  logic [9:0]                  target_q, target_d;
  logic [9:0]                  paddle_q, paddle_d;
  logic                        moved_q;

  logic                        tick;
  logic [7:0]                  avg;
  logic [8:0]                  diff9, mag9;
  logic                        filt_upd;
  logic [17:0]                 prod;
  logic [9:0]                  up_gap, dn_gap;

  assign tick  = (cnt_q == CW'(SAMPLE_DIV - 1));
  // Replace the oldest sample in the running sum; the sum never exceeds
  // DEPTH*255 so SW bits always suffice.
  assign sum_d = sum_q + SW'(pif.value) - SW'(smp_q[wp_q]);
  assign avg   = 8'(sum_q >> AVG_LOG2);

  // Unsigned magnitude of avg - filt at 9 bits.
  assign diff9    = {1'b0, avg} - {1'b0, filt_q};
  assign mag9     = diff9[8] ? (~diff9 + 9'd1) : diff9;
  assign filt_upd = tick_d1_q && (mag9 >= 9'(DEADBAND));

  assign prod     = 18'(filt_q) * 18'(Y_RANGE);
  assign target_d = prod[17:8];

  // Step toward the target; min() against the gap keeps us from overshooting.
  assign up_gap = target_q - paddle_q;
  assign dn_gap = paddle_q - target_q;
  always_comb begin
    paddle_d = paddle_q;
    if (pif.frame_tick) begin
      if (target_q > paddle_q)
        paddle_d = paddle_q + ((up_gap > STEP) ? STEP : up_gap);
      else if (target_q < paddle_q)
        paddle_d = paddle_q - ((dn_gap > STEP) ? STEP : dn_gap);
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      smp_q     <= '0;
      wp_q      <= '0;
      sum_q     <= '0;
      tick_d1_q <= 1'b0;
      filt_q    <= '0;
      target_q  <= '0;
      paddle_q  <= '0;
      moved_q   <= 1'b0;
    end else begin
      cnt_q     <= tick ? '0 : cnt_q + CW'(1);
      tick_d1_q <= tick;
      if (tick) begin
        sum_q       <= sum_d;
        smp_q[wp_q] <= pif.value;
        wp_q        <= wp_q + AVG_LOG2'(1);   // depth is a power of two
      end
      if (filt_upd) filt_q <= avg;
      target_q  <= target_d;
      paddle_q  <= paddle_d;
      moved_q   <= (paddle_d != paddle_q);
    end
  end

  assign pif.filt_value = filt_q;
  assign pif.paddle_y   = paddle_q;
  assign pif.moved      = moved_q;
endmodule

// File: tb/tb_pot_paddle_filter.sv
module tb_pot_paddle_filter;
  localparam int SDIV = 4, AL = 3, DB = 2, YR = 400, MS = 4;
  localparam int DEPTH = 1 << AL;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 sys_clk = ~sys_clk;

  pot_paddle_filter_if pif();

  pot_paddle_filter #(.SAMPLE_DIV(SDIV), .AVG_LOG2(AL), .DEADBAND(DB),
                      .Y_RANGE(YR), .MAX_STEP(MS))
    dut (.sys_clk(sys_clk), .reset(reset), .pif(pif));

  int total = 0, bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: sample history as a queue, average as plain division.
  int q[$];
  int m_cyc, m_filt, m_tgt, m_pad, old_t, a, gap;
  bit m_pend, m_moved;

  function automatic int qavg();
    int s = 0;
    foreach (q[i]) s += q[i];
    return s / DEPTH;
  endfunction

  always @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      q = {};
      for (int i = 0; i < DEPTH; i++) q.push_back(0);
      m_cyc = 0; m_filt = 0; m_tgt = 0; m_pad = 0; m_pend = 0; m_moved = 0;
    end else begin
      old_t = m_tgt;
      m_tgt = m_filt * YR / 256;
      if (m_pend) begin
        a = qavg();
        if (((a > m_filt) ? a - m_filt : m_filt - a) >= DB) m_filt = a;
      end
      m_moved = 0;
      if (pif.frame_tick && old_t != m_pad) begin
        gap = (old_t > m_pad) ? old_t - m_pad : m_pad - old_t;
        if (gap > MS) gap = MS;
        m_pad = (old_t > m_pad) ? m_pad + gap : m_pad - gap;
        m_moved = 1;
      end
      m_pend = (m_cyc % SDIV) == SDIV - 1;
      if (m_pend) begin
        q.push_back(int'(pif.value));
        void'(q.pop_front());
      end
      m_cyc++;
    end
  end

  always @(negedge sys_clk) begin
    if (chk_en) begin
      chk("cyc_filt",   pif.filt_value, m_filt);
      chk("cyc_paddle", pif.paddle_y,   m_pad);
      chk("cyc_moved",  pif.moved,      m_moved);
    end
  end

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk) pif.frame_tick = 1'b1;
      @(negedge sys_clk) pif.frame_tick = 1'b0;
    end
  endtask

  initial begin
    pif.value = 8'd0;
    pif.frame_tick = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_filt",   pif.filt_value, 0);
    chk("rst_paddle", pif.paddle_y,   0);
    chk("rst_moved",  pif.moved,      0);
    @(negedge sys_clk) reset = 1'b1;
    chk_en = 1'b1;

    // Start-up ramp: 10, 20, ... 80
    pif.value = 8'd80;
    for (int k = 1; k <= 8; k++) begin
      repeat ((k == 1) ? 5 : 4) @(negedge sys_clk);
      chk("ramp", pif.filt_value, 10 * k);
    end

    // Deadband
    pif.value = 8'd100; repeat (40) @(negedge sys_clk);
    chk("db_settle", pif.filt_value, 100);
    pif.value = 8'd101; repeat (40) @(negedge sys_clk);
    chk("db_hold", pif.filt_value, 100);
    pif.value = 8'd110; repeat (40) @(negedge sys_clk);
    chk("db_move", pif.filt_value != 8'd100, 1);

    // Full scale, then rate-limited climb to 398
    pif.value = 8'd255; repeat (40) @(negedge sys_clk);
    chk("filt_max", pif.filt_value, 255);
    for (int i = 1; i <= 100; i++) begin
      @(negedge sys_clk) pif.frame_tick = 1'b1;
      @(negedge sys_clk) pif.frame_tick = 1'b0;
      chk("rate_paddle", pif.paddle_y, (4 * i < 398) ? 4 * i : 398);
      chk("rate_moved",  pif.moved, 1);
    end
    frames(1);
    chk("rate_stop_paddle", pif.paddle_y, 398);
    chk("rate_stop_moved",  pif.moved, 0);

    // Mid-scale target 200, then asynchronous reset mid-run
    pif.value = 8'd128; repeat (40) @(negedge sys_clk);
    frames(60);
    chk("mid_paddle", pif.paddle_y, 200);
    @(negedge sys_clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_paddle", pif.paddle_y,   0);
    chk("arst_filt",   pif.filt_value, 0);
    chk("arst_moved",  pif.moved,      0);
    @(negedge sys_clk) reset = 1'b1;
    pif.value = 8'd200;
    repeat (4) @(negedge sys_clk);
    chk("first_tick_pre", pif.filt_value, 0);
    @(negedge sys_clk);
    chk("first_tick", pif.filt_value, 25);

    // Zero scale
    pif.value = 8'd0; repeat (40) @(negedge sys_clk);
    frames(110);
    chk("zero_paddle", pif.paddle_y, 0);

    // Frame tick on the edge where target_y is refreshed uses the old target
    begin
      int guard = 0;
      while ((m_cyc % SDIV) != SDIV - 1 && guard < 16) begin
        @(negedge sys_clk); guard++;
      end
      chk("align", (m_cyc % SDIV), SDIV - 1);
    end
    pif.value = 8'd255;
    @(negedge sys_clk);                 // E0 then
    @(negedge sys_clk);                 // E1 then
    pif.frame_tick = 1'b1;              // lands on E2
    @(negedge sys_clk) pif.frame_tick = 1'b0;
    chk("simul_old_paddle", pif.paddle_y, 0);
    chk("simul_old_moved",  pif.moved, 0);
    frames(1);
    chk("simul_new_paddle", pif.paddle_y, 4);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge sys_clk);
      if ($urandom_range(15) == 0) pif.value = 8'($urandom);
      pif.frame_tick = ($urandom_range(2) == 0);
    end
    pif.frame_tick = 1'b0;
    @(negedge sys_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
